// File: rtl/tge_snap_pkg.sv
// Shared definitions for the 10GbE RX snapshot capture controller:
// FSM encoding, control-word bit indices and status-word layout.
package tge_snap_pkg;

  // Capture FSM encoding as seen by software in status[29:28]
  typedef enum logic [1:0] {
    SNAP_IDLE      = 2'd0,
    SNAP_WAIT_TRIG = 2'd1,
    SNAP_CAPTURE   = 2'd2,
    SNAP_DONE      = 2'd3
  } snap_state_e;

  // Plain constants for the FSM register, same encoding as the enum
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_TRIG = 2'd1;
  localparam logic [1:0] ST_CAPTURE   = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  // Control word bit indices
  localparam int CTRL_ARM   = 0;
  localparam int CTRL_TRIG  = 1;
  localparam int CTRL_WE    = 2;
  localparam int CTRL_EOF   = 3;
  localparam int CTRL_ABORT = 4;

  // Status word bit positions
  localparam int STAT_DONE     = 31;
  localparam int STAT_BUSY     = 30;
  localparam int STAT_STATE_HI = 29;
  localparam int STAT_STATE_LO = 28;
  // Count field is wide enough for the deepest legal capture (2^16 words)
  localparam int STAT_CNT_W    = 17;

  // Assemble the software-visible status word from FSM state and word count
  function automatic logic [31:0] pack_status(input logic [1:0]            st,
                                              input logic [STAT_CNT_W-1:0] cnt);
    logic [31:0] s;
    s                              = '0;
    s[STAT_DONE]                   = (st == ST_DONE);
    s[STAT_BUSY]                   = (st == ST_WAIT_TRIG) || (st == ST_CAPTURE);
    s[STAT_STATE_HI:STAT_STATE_LO] = st;
    s[STAT_CNT_W-1:0]              = cnt;
    return s;
  endfunction

endpackage

// File: rtl/tge_rx_snap_ctrl_if.sv
// RX stream and snapshot BRAM write port bundle.
// master: the capture controller (consumes RX, drives BRAM).
// slave : the surrounding system (drives RX, consumes BRAM writes).
interface tge_rx_snap_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64
) ();

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_eof;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_we;

  modport master (
    input  rx_data, rx_valid, rx_eof,
    output bram_addr, bram_din, bram_we
  );

  modport slave (
    output rx_data, rx_valid, rx_eof,
    input  bram_addr, bram_din, bram_we
  );

endinterface

// File: rtl/tge_snap_edge_det.sv
// Single-bit rising-edge detector. The history flop reset value is a
// parameter so a level already high when reset releases can be treated
// as "seen" and not produce a spurious edge.
module tge_snap_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  // Next history value is simply the current input level
  always_comb begin
    d_d = d;
  end

  // History register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q <= RST_VAL;
    end else begin
      d_q <= d_d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/tge_rx_snap_ctrl.sv
// RX snapshot capture controller. Waits for an arm edge, optionally for
// the next frame start, then streams RX words into the snapshot BRAM
// until the buffer fills or (optionally) a frame ends. Reports progress
// through a status word. All BRAM outputs are registered.
module tge_rx_snap_ctrl
  import tge_snap_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64
) (
  input  logic                 user_clk,
  input  logic                 user_rst_n,
  input  logic [31:0]          ctrl,
  tge_rx_snap_ctrl_if.master   bus,
  output logic [31:0]          status
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  // Decoded control bits
  logic arm_edge;
  logic trig_sel;
  logic we_sel;
  logic stop_on_eof;
  logic abort;

  // Upper control bits are reserved
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^ctrl[31:5];

  assign trig_sel    = ctrl[CTRL_TRIG];
  assign we_sel      = ctrl[CTRL_WE];
  assign stop_on_eof = ctrl[CTRL_EOF];
  assign abort       = ctrl[CTRL_ABORT];

  // Arm history resets high: an arm bit held through reset is not an edge
  tge_snap_edge_det #(
    .RST_VAL (1'b1)
  ) u_arm_edge (
    .clk   (user_clk),
    .rst_n (user_rst_n),
    .d     (ctrl[CTRL_ARM]),
    .rise  (arm_edge)
  );

  // State registers
  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [ADDR_W:0]   count_q,     count_d;
  logic              in_frame_q,  in_frame_d;
  logic              bram_we_q,   bram_we_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_din_q,  bram_din_d;

  logic frame_start;
  logic store;
  logic last_addr;
  logic eof_stop;

  assign frame_start = bus.rx_valid & ~in_frame_q;
  assign last_addr   = (addr_q == {ADDR_W{1'b1}});
  assign eof_stop    = stop_on_eof & bus.rx_valid & bus.rx_eof;

  // Frame tracker: inside a frame after a non-final valid word
  always_comb begin
    in_frame_d = in_frame_q;
    if (bus.rx_valid) begin
      in_frame_d = ~bus.rx_eof;
    end
  end

  // Capture FSM, address/count counters and BRAM write staging
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    bram_we_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    store       = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm_edge) begin
          addr_d  = '0;
          count_d = '0;
          state_d = trig_sel ? ST_WAIT_TRIG : ST_CAPTURE;
        end
      end
      ST_WAIT_TRIG: begin
        // The frame-start word itself is the first word captured
        store = frame_start;
      end
      ST_CAPTURE: begin
        store = we_sel | bus.rx_valid;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (store) begin
      bram_we_d   = 1'b1;
      bram_addr_d = addr_q;
      bram_din_d  = bus.rx_data;
      addr_d      = addr_q + ADDR_ONE;
      count_d     = count_q + CNT_ONE;
      // Full buffer and EOF stop may coincide; either gives one DONE
      if (last_addr || eof_stop) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_CAPTURE;
      end
    end

    // Abort wins over everything, including a same-cycle arm edge
    if (abort) begin
      state_d     = ST_IDLE;
      addr_d      = addr_q;
      count_d     = count_q;
      bram_we_d   = 1'b0;
      bram_addr_d = bram_addr_q;
      bram_din_d  = bram_din_q;
    end
  end

  // Register update with synchronous active-low reset
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      in_frame_q  <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      in_frame_q  <= in_frame_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
    end
  end

  assign bus.bram_we   = bram_we_q;
  assign bus.bram_addr = bram_addr_q;
  assign bus.bram_din  = bram_din_q;

  // Status is a pure function of registered state, so it moves with bram_we
  assign status = pack_status(state_q, STAT_CNT_W'(count_q));

endmodule

// File: tb/tb_tge_rx_snap_ctrl.sv
// Directed bench for the RX snapshot capture controller (ADDR_W=4).
// Inputs are driven 1 time unit after each rising edge; outputs are
// sampled at that same point, so they reflect the inputs of the cycle
// just completed.
module tb_tge_rx_snap_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 64;

  logic        user_clk;
  logic        user_rst_n;
  logic [31:0] ctrl;
  logic [31:0] status;

  int checks;
  int errors;
  int k;

  tge_rx_snap_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  tge_rx_snap_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .ctrl       (ctrl),
    .bus        (bus_if),
    .status     (status)
  );

  initial begin
    user_clk = 1'b0;
    forever #5 user_clk = ~user_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rx(input logic v, input logic e, input logic [63:0] d);
    bus_if.rx_valid = v;
    bus_if.rx_eof   = e;
    bus_if.rx_data  = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    user_rst_n = 1'b0;
    ctrl = 32'h0;
    rx(1'b0, 1'b0, 64'h0);

    // Reset state
    tick();
    tick();
    chk("rst_status", 64'(status), 64'h0);
    chk("rst_we", 64'(bus_if.bram_we), 64'h0);
    chk("rst_addr", 64'(bus_if.bram_addr), 64'h0);
    chk("rst_din", bus_if.bram_din, 64'h0);
    user_rst_n = 1'b1;
    tick();

    // Immediate capture, valid every other cycle
    ctrl = 32'h1;
    tick();
    chk("imm_arm_status", 64'(status), 64'h6000_0000);
    k = 0;
    for (int i = 0; i < 31; i++) begin
      rx((i % 2) == 0, 1'b0, 64'hA000 + 64'(i));
      tick();
      if ((i % 2) == 0) begin
        chk("imm_we", 64'(bus_if.bram_we), 64'h1);
        chk("imm_addr", 64'(bus_if.bram_addr), 64'(k));
        chk("imm_din", bus_if.bram_din, 64'hA000 + 64'(i));
        k++;
      end else begin
        chk("imm_gap_we", 64'(bus_if.bram_we), 64'h0);
      end
    end
    chk("imm_done_status", 64'(status), 64'hB000_0010);
    rx(1'b1, 1'b0, 64'hDEAD);
    tick();
    chk("imm_after_done_we", 64'(bus_if.bram_we), 64'h0);
    chk("imm_after_done_status", 64'(status), 64'hB000_0010);

    // Re-arm from DONE; arm edge during CAPTURE is ignored
    ctrl = 32'h0;
    rx(1'b0, 1'b0, 64'h0);
    tick();
    ctrl = 32'h1;
    rx(1'b1, 1'b0, 64'hBAD0);
    tick();
    chk("rearm_we", 64'(bus_if.bram_we), 64'h0);
    chk("rearm_status", 64'(status), 64'h6000_0000);
    for (int j = 0; j < 7; j++) begin
      rx(1'b1, 1'b0, 64'hB000 + 64'(j));
      if (j == 2) ctrl = 32'h0;
      if (j == 3) ctrl = 32'h1;
      tick();
      chk("rearm_addr", 64'(bus_if.bram_addr), 64'(j));
      chk("rearm_din", bus_if.bram_din, 64'hB000 + 64'(j));
      if (j == 4) chk("rearm_ignored_status", 64'(status), 64'h6000_0005);
    end
    chk("rearm_7_status", 64'(status), 64'h6000_0007);

    // Abort after 7 writes
    ctrl = 32'h11;
    rx(1'b1, 1'b0, 64'hB007);
    tick();
    chk("abort_we", 64'(bus_if.bram_we), 64'h0);
    chk("abort_status", 64'(status), 64'h0000_0007);
    ctrl = 32'h10;
    tick();
    ctrl = 32'h11;
    tick();
    chk("abort_arm_status", 64'(status), 64'h0000_0007);
    chk("abort_arm_we", 64'(bus_if.bram_we), 64'h0);
    ctrl = 32'h0;
    rx(1'b0, 1'b0, 64'h0);
    tick();

    // Frame trigger, armed mid-frame
    rx(1'b1, 1'b0, 64'hC0);
    tick();
    chk("ftrig_idle_we", 64'(bus_if.bram_we), 64'h0);
    ctrl = 32'h3;
    rx(1'b1, 1'b0, 64'hC1);
    tick();
    chk("ftrig_wait_status", 64'(status), 64'h5000_0000);
    chk("ftrig_arm_we", 64'(bus_if.bram_we), 64'h0);
    rx(1'b1, 1'b0, 64'hC2);
    tick();
    chk("ftrig_mid_we", 64'(bus_if.bram_we), 64'h0);
    rx(1'b1, 1'b1, 64'hC3);
    tick();
    chk("ftrig_eof_we", 64'(bus_if.bram_we), 64'h0);
    rx(1'b0, 1'b0, 64'h0);
    tick();
    chk("ftrig_gap_we", 64'(bus_if.bram_we), 64'h0);
    chk("ftrig_gap_status", 64'(status), 64'h5000_0000);
    rx(1'b1, 1'b0, 64'hD0);
    tick();
    chk("ftrig_first_we", 64'(bus_if.bram_we), 64'h1);
    chk("ftrig_first_addr", 64'(bus_if.bram_addr), 64'h0);
    chk("ftrig_first_din", bus_if.bram_din, 64'hD0);
    chk("ftrig_first_status", 64'(status), 64'h6000_0001);
    rx(1'b1, 1'b0, 64'hD1);
    tick();
    chk("ftrig_second_addr", 64'(bus_if.bram_addr), 64'h1);
    chk("ftrig_second_din", bus_if.bram_din, 64'hD1);
    ctrl = 32'h13;
    rx(1'b0, 1'b0, 64'h0);
    tick();
    chk("ftrig_abort_status", 64'(status), 64'h0000_0002);
    ctrl = 32'h0;
    tick();

    // EOF stop with a 5-word frame
    ctrl = 32'h9;
    tick();
    chk("eof5_arm_status", 64'(status), 64'h6000_0000);
    for (int j = 0; j < 5; j++) begin
      rx(1'b1, j == 4, 64'hE0 + 64'(j));
      tick();
      chk("eof5_addr", 64'(bus_if.bram_addr), 64'(j));
      chk("eof5_din", bus_if.bram_din, 64'hE0 + 64'(j));
    end
    chk("eof5_status", 64'(status), 64'hB000_0005);
    rx(1'b1, 1'b0, 64'hEE);
    tick();
    chk("eof5_after_we", 64'(bus_if.bram_we), 64'h0);
    chk("eof5_after_status", 64'(status), 64'hB000_0005);

    // EOF coinciding with the last address
    ctrl = 32'h0;
    rx(1'b0, 1'b0, 64'h0);
    tick();
    ctrl = 32'h9;
    tick();
    for (int j = 0; j < 16; j++) begin
      rx(1'b1, j == 15, 64'hF00 + 64'(j));
      tick();
      chk("eof16_we", 64'(bus_if.bram_we), 64'h1);
      chk("eof16_addr", 64'(bus_if.bram_addr), 64'(j));
    end
    chk("eof16_status", 64'(status), 64'hB000_0010);
    rx(1'b0, 1'b0, 64'h0);
    tick();
    chk("eof16_after_we", 64'(bus_if.bram_we), 64'h0);
    chk("eof16_after_status", 64'(status), 64'hB000_0010);

    // Store-every-cycle mode writes even without rx_valid
    ctrl = 32'h0;
    tick();
    ctrl = 32'h5;
    tick();
    chk("wesel_arm_status", 64'(status), 64'h6000_0000);
    rx(1'b0, 1'b0, 64'h5A0);
    tick();
    chk("wesel_we0", 64'(bus_if.bram_we), 64'h1);
    chk("wesel_addr0", 64'(bus_if.bram_addr), 64'h0);
    chk("wesel_din0", bus_if.bram_din, 64'h5A0);
    rx(1'b0, 1'b0, 64'h5A1);
    tick();
    chk("wesel_addr1", 64'(bus_if.bram_addr), 64'h1);
    ctrl = 32'h15;
    tick();
    chk("wesel_abort_we", 64'(bus_if.bram_we), 64'h0);
    chk("wesel_abort_status", 64'(status), 64'h0000_0002);
    ctrl = 32'h0;
    tick();

    // Reset mid-capture at the 9th write, arm held high through reset
    ctrl = 32'h1;
    tick();
    chk("rstmid_arm_status", 64'(status), 64'h6000_0000);
    for (int j = 0; j < 8; j++) begin
      rx(1'b1, 1'b0, 64'h9000 + 64'(j));
      tick();
    end
    chk("rstmid_pre_status", 64'(status), 64'h6000_0008);
    user_rst_n = 1'b0;
    rx(1'b1, 1'b0, 64'h9008);
    tick();
    chk("rstmid_status", 64'(status), 64'h0);
    chk("rstmid_we", 64'(bus_if.bram_we), 64'h0);
    chk("rstmid_addr", 64'(bus_if.bram_addr), 64'h0);
    chk("rstmid_din", bus_if.bram_din, 64'h0);
    user_rst_n = 1'b1;
    tick();
    chk("rstheld_status0", 64'(status), 64'h0);
    tick();
    tick();
    chk("rstheld_status", 64'(status), 64'h0);
    chk("rstheld_we", 64'(bus_if.bram_we), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tge_rx_snap_ctrl.md
# tge_rx_snap_ctrl

Capture controller for the 10GbE RX snapshot path. It takes the software control word written through the RX snapshot control register, waits for a trigger, and then sequences writes of the RX data stream into the snapshot BRAM. When the capture finishes it reports done, busy, state and word count as a status word that software reads back. It sits in the `user_clk` domain between the gbe0 RX interface, the ctrl register output and the snapshot BRAM write port.

## Interface
- `ADDR_W`, 11: BRAM address width; capture depth is 2^ADDR_W words (legal 4..16).
- `DATA_W`, 64: RX data and BRAM data width.
- `user_clk`  in  1  sole clock; all logic is on its rising edge.
- `user_rst_n`  in  1  reset, synchronous and active-low.
- `ctrl`  in  32  software control word, already in the `user_clk` domain:
  - [0] arm, rising edge starts a capture;
  - [1] trig_sel: 0 = immediate, 1 = next frame start;
  - [2] we_sel: 0 = store valid words only, 1 = store every cycle;
  - [3] stop_on_eof;
  - [4] abort, level-sensitive.
- `rx_data`  in  DATA_W  RX data word.
- `rx_valid`  in  1  `rx_data` is valid this cycle.
- `rx_eof`  in  1  last word of a frame; qualified by `rx_valid`.
- `bram_addr`  out  ADDR_W  BRAM write address.
- `bram_din`  out  DATA_W  BRAM write data.
- `bram_we`  out  1  BRAM write enable.
- `status`  out  32  status word:
  - [31] done;
  - [30] busy;
  - [29:28] state;
  - [ADDR_W:0] word count;
  - all other bits 0.

## Operation
- **States:** IDLE=0, WAIT_TRIG=1, CAPTURE=2, DONE=3.
- **Arm edge:** `arm_q` registers `ctrl[0]`; `arm_edge` = `ctrl[0]` & ~`arm_q`. `arm_q` resets to 1, so an arm bit held high through reset is not taken as an edge.
- **Frame tracking:** `in_frame` is set on `rx_valid` & ~`rx_eof` and cleared on `rx_valid` & `rx_eof`; it resets to 0. A frame start is `rx_valid` & ~`in_frame`.
- **IDLE / DONE:**
  - On `arm_edge`, clear the count and address.
  - Go to WAIT_TRIG if trig_sel=1, otherwise to CAPTURE.
- **WAIT_TRIG:** on a frame start, that word is stored and the state moves to CAPTURE.
- **CAPTURE:**
  - A word is stored when we_sel=1, or when we_sel=0 and `rx_valid`=1.
  - Each stored word is written at the current address; then the address and count increment.
- **Capture ends (go to DONE) when either:**
  - the word at address 2^ADDR_W−1 is stored (count = 2^ADDR_W), or
  - stop_on_eof=1 and a stored word has `rx_eof`=1 with `rx_valid`=1.
- **Both end conditions on the same word:** a single transition to DONE; count = 2^ADDR_W.
- **`arm_edge` during WAIT_TRIG or CAPTURE:** ignored. A falling edge of arm never aborts a capture.
- **abort=1:** forces IDLE on the next edge from any state and takes precedence over `arm_edge`. The count is held; done=0.
- **Mode bits:** trig_sel, we_sel and stop_on_eof are sampled every cycle. Software must not change them mid-capture; the result of doing so is undefined but must stay in a legal state.
- **Status bits:** done=1 only in DONE; busy=1 in WAIT_TRIG or CAPTURE.
- **Reset values:** state IDLE, address 0, count 0, `bram_we`=0, `bram_din`=0, `bram_addr`=0, `status`=0, `in_frame`=0, `arm_q`=1.

## Timing
- **Arm to state change:** `ctrl[0]` goes high at edge N, giving `arm_edge` in cycle N; the state changes at edge N+1.
- **Data path:** all BRAM outputs are registered. An RX word stored in cycle M appears on `bram_we`/`bram_addr`/`bram_din` in cycle M+1, for one cycle per word.
- **Status:** count and state update at the same edge as the corresponding `bram_we` assertion, so done is visible in the cycle after the final stored word.
- **Throughput:** one word per cycle sustained, no bubbles.
- **Reset:** takes effect at the first edge with `user_rst_n`=0, including mid-capture. Any in-flight write is dropped (`bram_we`=0).

## Structure
- **Package `tge_snap_pkg`:**
  - state enum (2 bits, encoding as above);
  - ctrl bit indices `CTRL_ARM`=0, `CTRL_TRIG`=1, `CTRL_WE`=2, `CTRL_EOF`=3, `CTRL_ABORT`=4;
  - status bit positions.
- **Sub-module `tge_snap_edge_det`:** rising-edge detector with a reset-value parameter, used for arm.
- **Top level:** FSM, frame tracker, address/count counters and output registers.

## Test plan
- **Immediate capture:** ADDR_W=4, ctrl=0x1 (edge), `rx_valid` every other cycle → 16 writes to addr 0..15 carrying the valid data; then done=1, count=16, `status`=0xB0000010.
- **Frame trigger:** ctrl=0x3, arm mid-frame → nothing is written until the word after `rx_eof`; the first write is that frame-start word at addr 0.
- **EOF stop:** ctrl=0x9, frame of 5 valid words → writes at addr 0..4, done, count=5. Repeat with the frame ending exactly at addr 15 → single DONE, count=16.
- **Abort:** ctrl=0x11 after 7 writes → IDLE next cycle, `bram_we`=0, count=7, done=0. Simultaneous arm edge and abort → remains IDLE.
- **Reset mid-capture:** `user_rst_n`=0 at write 9 → `status`=0 and `bram_we`=0 at the next edge. `ctrl[0]` held high through reset → no capture starts.
- **Re-arm from DONE:** arm 0→1 again → count clears and the capture restarts at addr 0. An arm edge during CAPTURE is ignored.
